// File: rtl/ct_idu_mat_lsu_issue_queue_if.sv
// ct_idu_mat_lsu_issue_queue_if: dispatch, flush, completion and RF issue signals of the matrix LSU issue queue
interface ct_idu_mat_lsu_issue_queue_if;
  logic        rtu_yy_xx_flush;
  logic        dp_mat_lsu_vld;
  logic [6:0]  dp_mat_lsu_iid;
  logic [1:0]  dp_mat_lsu_op;
  logic        dp_mat_lsu_dstm_vld;
  logic [2:0]  dp_mat_lsu_dstm_idx;
  logic        dp_mat_lsu_src2m_vld;
  logic [2:0]  dp_mat_lsu_src2m_idx;
  logic        dp_mat_lsu_nf_vld;
  logic [2:0]  dp_mat_lsu_nf;
  logic [1:0]  dp_mat_lsu_elm_width;
  logic [63:0] dp_mat_lsu_src0;
  logic        dp_mat_lsu_src1_vld;
  logic [63:0] dp_mat_lsu_src1;
  logic        mat_lsu_dp_rdy;
  logic        mat_lsu_cbus_ex1_pipe8_sel;
  logic        idu_mat_rf_lsu_sel;
  logic        idu_mat_rf_lsu_gateclk_sel;
  logic [6:0]  idu_mat_rf_pipe8_iid;
  logic [15:0] idu_mat_rf_pipe8_lsu_meta;
  logic [63:0] idu_mat_rf_pipe8_lsu_src0;
  logic        idu_mat_rf_pipe8_lsu_src1_vld;
  logic [63:0] idu_mat_rf_pipe8_lsu_src1;
  logic        mat_lsu_iq_empty;

  modport master (
    output rtu_yy_xx_flush, dp_mat_lsu_vld, dp_mat_lsu_iid, dp_mat_lsu_op,
           dp_mat_lsu_dstm_vld, dp_mat_lsu_dstm_idx, dp_mat_lsu_src2m_vld, dp_mat_lsu_src2m_idx,
           dp_mat_lsu_nf_vld, dp_mat_lsu_nf, dp_mat_lsu_elm_width, dp_mat_lsu_src0,
           dp_mat_lsu_src1_vld, dp_mat_lsu_src1, mat_lsu_cbus_ex1_pipe8_sel,
    input  mat_lsu_dp_rdy, idu_mat_rf_lsu_sel, idu_mat_rf_lsu_gateclk_sel, idu_mat_rf_pipe8_iid,
           idu_mat_rf_pipe8_lsu_meta, idu_mat_rf_pipe8_lsu_src0, idu_mat_rf_pipe8_lsu_src1_vld,
           idu_mat_rf_pipe8_lsu_src1, mat_lsu_iq_empty
  );

  modport slave (
    input  rtu_yy_xx_flush, dp_mat_lsu_vld, dp_mat_lsu_iid, dp_mat_lsu_op,
           dp_mat_lsu_dstm_vld, dp_mat_lsu_dstm_idx, dp_mat_lsu_src2m_vld, dp_mat_lsu_src2m_idx,
           dp_mat_lsu_nf_vld, dp_mat_lsu_nf, dp_mat_lsu_elm_width, dp_mat_lsu_src0,
           dp_mat_lsu_src1_vld, dp_mat_lsu_src1, mat_lsu_cbus_ex1_pipe8_sel,
    output mat_lsu_dp_rdy, idu_mat_rf_lsu_sel, idu_mat_rf_lsu_gateclk_sel, idu_mat_rf_pipe8_iid,
           idu_mat_rf_pipe8_lsu_meta, idu_mat_rf_pipe8_lsu_src0, idu_mat_rf_pipe8_lsu_src1_vld,
           idu_mat_rf_pipe8_lsu_src1, mat_lsu_iq_empty
  );
endinterface

// File: rtl/ct_idu_mat_lsu_issue_queue.sv
// ct_idu_mat_lsu_issue_queue: in-order matrix LSU issue FIFO throttled by an outstanding-issue counter
module ct_idu_mat_lsu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic forever_cpuclk,
  input logic cpurst,
  ct_idu_mat_lsu_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = 152;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [OW:0] OUT_MAX = MAX_OUTSTANDING[OW:0];

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [OW-1:0] outstanding;
  logic [OW:0]   out_next;
  logic          sel_q;
  logic          gate_q;
  logic [6:0]    iid_q;
  logic [15:0]   meta_q;
  logic [63:0]   src0_q;
  logic          src1_vld_q;
  logic [63:0]   src1_q;
  logic          flush;
  logic          cbus;
  logic          empty;
  logic          full;
  logic          push;
  logic          issue;
  logic          pop;
  logic          underflow;
  logic [15:0]   meta_in;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;

  assign flush = bus.rtu_yy_xx_flush;
  assign cbus  = bus.mat_lsu_cbus_ex1_pipe8_sel;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.dp_mat_lsu_vld && !full && !flush;

  // The counter a cycle ahead: the issue currently on sel is already in flight,
  // and a completion arriving this cycle frees its slot immediately.
  assign underflow = cbus && !sel_q && outstanding == '0;
  assign out_next  = underflow ? '0 : {1'b0, outstanding} + {{OW{1'b0}}, sel_q} - {{OW{1'b0}}, cbus};
  assign issue     = !empty && (out_next < OUT_MAX);
  assign pop       = issue && !flush;

  assign meta_in  = {bus.dp_mat_lsu_op, bus.dp_mat_lsu_dstm_vld, bus.dp_mat_lsu_dstm_idx,
                     bus.dp_mat_lsu_src2m_vld, bus.dp_mat_lsu_src2m_idx, bus.dp_mat_lsu_nf_vld,
                     bus.dp_mat_lsu_nf, bus.dp_mat_lsu_elm_width};
  assign entry_in = {bus.dp_mat_lsu_iid, meta_in, bus.dp_mat_lsu_src0, bus.dp_mat_lsu_src1_vld,
                     bus.dp_mat_lsu_src1};
  assign head     = mem[rd_ptr[AW-1:0]];

  // Entry storage needs no reset: only slots between the pointers are ever read out
  always_ff @(posedge forever_cpuclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry_in;
  end

  // Pointers, outstanding counter and issue strobes; flush empties the queue and forgets in-flight issues
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      sel_q       <= 1'b0;
      gate_q      <= 1'b0;
    end else begin
      wr_ptr      <= flush ? '0 : push ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr      <= flush ? '0 : pop ? rd_ptr + PTR_ONE : rd_ptr;
      outstanding <= flush ? '0 : out_next[OW-1:0];
      sel_q       <= pop;
      gate_q      <= issue;
    end
  end

  // RF payload follows the raw issue condition so it lines up with the clock-gate enable
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      {iid_q, meta_q, src0_q, src1_vld_q, src1_q} <= '0;
    end else if (issue) begin
      {iid_q, meta_q, src0_q, src1_vld_q, src1_q} <= head;
    end
  end

  // Catch a dispatcher ignoring rdy and an LSU completing more than was issued
  always @(posedge forever_cpuclk) begin
    if (!cpurst) begin
      assert (!(bus.dp_mat_lsu_vld && full && !flush))
        else $error("mat lsu iq: dispatch dropped while queue full");
      assert (!underflow)
        else $warning("mat lsu iq: completion with nothing outstanding");
      assert ({1'b0, outstanding} <= OUT_MAX)
        else $error("mat lsu iq: outstanding count above limit");
    end
  end

  assign bus.mat_lsu_dp_rdy                = !full;
  assign bus.mat_lsu_iq_empty              = empty;
  assign bus.idu_mat_rf_lsu_sel            = sel_q;
  assign bus.idu_mat_rf_lsu_gateclk_sel    = gate_q;
  assign bus.idu_mat_rf_pipe8_iid          = iid_q;
  assign bus.idu_mat_rf_pipe8_lsu_meta     = meta_q;
  assign bus.idu_mat_rf_pipe8_lsu_src0     = src0_q;
  assign bus.idu_mat_rf_pipe8_lsu_src1_vld = src1_vld_q;
  assign bus.idu_mat_rf_pipe8_lsu_src1     = src1_q;
endmodule
